// File: rtl/ysyx_22041211_pkg.sv
// Shared definitions for the NPC operand-fetch stage: register index width,
// the zero-register constant and the payload of the EXU pipeline register.
package ysyx_22041211_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // Contents of the one-entry pipeline register handed to the EXU.
    typedef struct packed {
        logic [XLEN-1:0]      src1;
        logic [XLEN-1:0]      src2;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_wen;
    } rr_payload_t;

    // x0 never carries a dependency, so every hazard/set path filters it out.
    function automatic logic is_nonzero(input logic [REG_IDX_W-1:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/ysyx_22041211_scoreboard.sv
// Busy scoreboard for in-flight destination registers. One bit per
// architectural register, bit 0 permanently clear. A set and a clear aimed at
// the same index in one cycle leave the bit set, because the newer writer is
// the one now in flight. Three combinational lookups serve rs1, rs2 and rd.
module ysyx_22041211_scoreboard
    import ysyx_22041211_pkg::*;
#(
    parameter int NR_REGS = 32
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    input  logic                          set_en_i,
    input  logic [REG_IDX_W-1:0]          set_idx_i,
    input  logic                          clr_en_i,
    input  logic [REG_IDX_W-1:0]          clr_idx_i,
    input  logic [2:0][REG_IDX_W-1:0]     query_idx_i,
    output logic [2:0]                    query_busy_o
);

    logic [NR_REGS-1:0] busy_q;
    logic [NR_REGS-1:0] busy_d;

    // Next busy vector: clear first, then set, so a coincident set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i && is_nonzero(clr_idx_i)) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && is_nonzero(set_idx_i)) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register; reset empties the scoreboard at once.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_query
            assign query_busy_o[gi] = busy_q[query_idx_i[gi]];
        end
    endgenerate

endmodule

// File: rtl/ysyx_22041211_reg_read_stage.sv
// Operand-fetch stage between IDU and EXU. Drives register-file read
// addresses, stalls on RAW/WAW hazards against the busy scoreboard, and
// registers operands into a one-entry pipeline register for the EXU.
// Optional feature macro: RR_WB_BYPASS_EN forwards the committing writeback
// value straight into the operand and lifts the hazard in that same cycle.
// Without it, the instruction waits one cycle and reads the freshly written
// register file.
module ysyx_22041211_reg_read_stage
    import ysyx_22041211_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NR_REGS    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_IDX_W-1:0]   in_rs1,
    input  logic [REG_IDX_W-1:0]   in_rs2,
    input  logic                   in_use_rs1,
    input  logic                   in_use_rs2,
    input  logic [REG_IDX_W-1:0]   in_rd,
    input  logic                   in_rd_wen,
    output logic [REG_IDX_W-1:0]   rf_rsc1,
    output logic [REG_IDX_W-1:0]   rf_rsc2,
    input  logic [DATA_WIDTH-1:0]  rf_rdata1,
    input  logic [DATA_WIDTH-1:0]  rf_rdata2,
    input  logic                   wb_en,
    input  logic [REG_IDX_W-1:0]   wb_rd,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_src1,
    output logic [DATA_WIDTH-1:0]  out_src2,
    output logic [REG_IDX_W-1:0]   out_rd,
    output logic                   out_rd_wen
);

    logic [2:0][REG_IDX_W-1:0] query_idx;
    logic [2:0]                query_busy;
    logic                      hit_rs1;
    logic                      hit_rs2;
    logic                      hit_rd;
    logic                      haz_rs1;
    logic                      haz_rs2;
    logic                      haz_waw;
    logic                      stall;
    logic                      fire;
    logic                      rd_writes;
    logic [DATA_WIDTH-1:0]     src1_sel;
    logic [DATA_WIDTH-1:0]     src2_sel;
    rr_payload_t               payload_d;
    rr_payload_t               payload_q;
    logic                      out_valid_q;

    assign rf_rsc1 = in_rs1;
    assign rf_rsc2 = in_rs2;

    assign query_idx = {in_rd, in_rs2, in_rs1};

    ysyx_22041211_scoreboard #(
        .NR_REGS (NR_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_ni       (rst),
        .set_en_i     (fire && rd_writes),
        .set_idx_i    (in_rd),
        .clr_en_i     (wb_en),
        .clr_idx_i    (wb_rd),
        .query_idx_i  (query_idx),
        .query_busy_o (query_busy)
    );

`ifdef RR_WB_BYPASS_EN
    assign hit_rs1 = wb_en && (wb_rd == in_rs1) && is_nonzero(in_rs1);
    assign hit_rs2 = wb_en && (wb_rd == in_rs2) && is_nonzero(in_rs2);
    assign hit_rd  = wb_en && (wb_rd == in_rd)  && is_nonzero(in_rd);
`else
    assign hit_rs1 = 1'b0;
    assign hit_rs2 = 1'b0;
    assign hit_rd  = 1'b0;
`endif

    assign rd_writes = in_rd_wen && is_nonzero(in_rd);

    // Hazard detection never looks at in_valid, so in_ready is valid-independent.
    always_comb begin
        haz_rs1 = in_use_rs1 && is_nonzero(in_rs1) && query_busy[0] && !hit_rs1;
        haz_rs2 = in_use_rs2 && is_nonzero(in_rs2) && query_busy[1] && !hit_rs2;
        haz_waw = rd_writes && query_busy[2] && !hit_rd;
        stall   = haz_rs1 || haz_rs2 || haz_waw;
    end

    assign in_ready = (!out_valid_q || out_ready) && !stall;
    assign fire     = in_valid && in_ready;

    // Operand select: unused or x0 sources read as zero, then bypass, then RF.
    always_comb begin
        src1_sel = '0;
        src2_sel = '0;
        if (in_use_rs1 && is_nonzero(in_rs1)) begin
            src1_sel = hit_rs1 ? wb_data : rf_rdata1;
        end
        if (in_use_rs2 && is_nonzero(in_rs2)) begin
            src2_sel = hit_rs2 ? wb_data : rf_rdata2;
        end
        payload_d.src1   = XLEN'(src1_sel);
        payload_d.src2   = XLEN'(src2_sel);
        payload_d.rd     = in_rd;
        payload_d.rd_wen = rd_writes;
    end

    // EXU pipeline register: load on fire, drain on out_ready, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (fire) begin
            payload_q   <= payload_d;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_src1   = DATA_WIDTH'(payload_q.src1);
    assign out_src2   = DATA_WIDTH'(payload_q.src2);
    assign out_rd     = payload_q.rd;
    assign out_rd_wen = payload_q.rd_wen;

endmodule

// File: tb/tb_ysyx_22041211_reg_read_stage.sv
// Directed bench for the operand-fetch stage. Expected EXU transactions are
// queued when an instruction is driven into its accepting cycle and compared
// when the stage hands them over (out_valid && out_ready).
module tb_ysyx_22041211_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs1;
    logic        in_use_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [4:0]  rf_rsc1;
    logic [4:0]  rf_rsc2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [4:0]  out_rd;
    logic        out_rd_wen;

    always #5 clk = ~clk;

    ysyx_22041211_reg_read_stage #(
        .DATA_WIDTH (32),
        .NR_REGS    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_rs1 (in_use_rs1),
        .in_use_rs2 (in_use_rs2),
        .in_rd      (in_rd),
        .in_rd_wen  (in_rd_wen),
        .rf_rsc1    (rf_rsc1),
        .rf_rsc2    (rf_rsc2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src1   (out_src1),
        .out_src2   (out_src2),
        .out_rd     (out_rd),
        .out_rd_wen (out_rd_wen)
    );

    // Register-file model: reg i holds i*0x11, x0 deliberately returns 0xFFFF
    // so the stage's zeroing of x0 is visible. Writes land at the wb edge.
    logic [31:0] rf_model [32];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_model[i] <= 32'(i) * 32'h11;
            rf_model[0] <= 32'h0000_FFFF;
        end else if (wb_en) begin
            rf_model[wb_rd] <= wb_data;
        end
    end
    assign rf_rdata1 = rf_model[rf_rsc1];
    assign rf_rdata2 = rf_model[rf_rsc2];

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [31:0] s1, input logic [31:0] s2,
                            input logic [4:0] rd, input logic wen);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.rd = rd; e.wen = wen;
        exp_q.push_back(e);
        $display("push: src1=0x%08h src2=0x%08h rd=%0d wen=%0d", s1, s2, rd, wen);
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic wen);
        in_valid = 1'b1; in_rs1 = rs1; in_use_rs1 = u1;
        in_rs2 = rs2; in_use_rs2 = u2; in_rd = rd; in_rd_wen = wen;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs1 = 5'd0; in_use_rs1 = 1'b0;
        in_rs2 = 5'd0; in_use_rs2 = 1'b0; in_rd = 5'd0; in_rd_wen = 1'b0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_en = en; wb_rd = rd; wb_data = data;
    endtask

    // One cycle: check in_ready mid-cycle, then advance past the next edge.
    task automatic cyc(input logic exp_ready, input string tag);
        @(negedge clk);
        check(tag, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    // Consumer side: a transaction is handed over on each edge with out_valid && out_ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("out : src1=0x%08h src2=0x%08h rd=%0d wen=%0d", out_src1, out_src2, out_rd, out_rd_wen);
                check("out_src1", out_src1, e.s1);
                check("out_src2", out_src2, e.s2);
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_rd_wen", 32'(out_rd_wen), 32'(e.wen));
            end
        end
    end

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        idle();
        set_wb(1'b0, 5'd0, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_src1", out_src1, 32'd0);
        check("rst_out_src2", out_src2, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic issue and one-cycle latency
        set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0);
        push_exp(32'h11, 32'h22, 5'd4, 1'b0);
        check("rf_rsc1_copy", 32'(rf_rsc1), 32'd1);
        cyc(1'b1, "basic_issue");
        idle();
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // RAW on rd=5
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        push_exp(32'd0, 32'd0, 5'd5, 1'b1);
        cyc(1'b1, "raw_producer");
        set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
        cyc(1'b0, "raw_stall_a");
        cyc(1'b0, "raw_stall_b");
        set_wb(1'b1, 5'd5, 32'hAB);
`ifdef RR_WB_BYPASS_EN
        push_exp(32'hAB, 32'd0, 5'd6, 1'b0);
        cyc(1'b1, "raw_bypass_issue");
        set_wb(1'b0, 5'd0, 32'd0);
`else
        cyc(1'b0, "raw_wb_cycle");
        set_wb(1'b0, 5'd0, 32'd0);
        push_exp(32'hAB, 32'd0, 5'd6, 1'b0);
        cyc(1'b1, "raw_release");
`endif

        // x0 handling, back-to-back throughput
        set_instr(5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1);
        push_exp(32'd0, 32'h22, 5'd0, 1'b0);
        cyc(1'b1, "x0_issue");
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        push_exp(32'h11, 32'd0, 5'd0, 1'b0);
        cyc(1'b1, "x0_back_to_back");

        // Back-pressure
        set_instr(5'd2, 1'b1, 5'd1, 1'b1, 5'd8, 1'b0);
        push_exp(32'h22, 32'h11, 5'd8, 1'b0);
        cyc(1'b1, "bp_first");
        out_ready = 1'b0;
        set_instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_src1", out_src1, 32'h22);
            check("bp_hold_src2", out_src2, 32'h11);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push_exp(32'h33, 32'h44, 5'd9, 1'b0);
        cyc(1'b1, "bp_release");

        // WAW on rd=7, then set-wins on coincident writeback
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        push_exp(32'd0, 32'd0, 5'd7, 1'b1);
        cyc(1'b1, "waw_first");
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cyc(1'b0, "waw_stall");
        set_wb(1'b1, 5'd7, 32'h77);
`ifdef RR_WB_BYPASS_EN
        push_exp(32'h11, 32'd0, 5'd7, 1'b1);
        cyc(1'b1, "waw_bypass_issue");
        set_wb(1'b0, 5'd0, 32'd0);
        set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
        cyc(1'b0, "set_wins_stall");
        set_wb(1'b1, 5'd7, 32'h99);
        push_exp(32'h99, 32'd0, 5'd10, 1'b0);
        cyc(1'b1, "set_wins_release");
        set_wb(1'b0, 5'd0, 32'd0);
`else
        cyc(1'b0, "waw_wb_cycle");
        set_wb(1'b0, 5'd0, 32'd0);
        push_exp(32'h11, 32'd0, 5'd7, 1'b1);
        cyc(1'b1, "waw_release");
        set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
        cyc(1'b0, "waw_reissue_busy");
        set_wb(1'b1, 5'd7, 32'h99);
        cyc(1'b0, "waw_wb2_cycle");
        set_wb(1'b0, 5'd0, 32'd0);
        push_exp(32'h99, 32'd0, 5'd10, 1'b0);
        cyc(1'b1, "waw_release2");
`endif

        // Asynchronous reset in the middle of a stall
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        push_exp(32'd0, 32'd0, 5'd3, 1'b1);
        cyc(1'b1, "rst_producer");
        out_ready = 1'b0;
        set_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0);
        @(negedge clk);
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_src1", out_src1, 32'd0);
        check("async_rst_rd", 32'(out_rd), 32'd0);
        check("async_rst_rd_wen", 32'(out_rd_wen), 32'd0);
        check("async_rst_busy_clear", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        push_exp(32'h33, 32'd0, 5'd11, 1'b0);
        cyc(1'b1, "post_rst_issue");

        // Drain
        idle();
        cyc(1'b1, "drain_a");
        cyc(1'b1, "drain_b");
        cyc(1'b1, "drain_c");
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
